rubytop_l1d_ld_miss_tracker: RTL and testbench
==============================================

# rubytop_l1d_ld_miss_tracker

L1D-side load-miss tracker that produces the sleep/wakeup protocol consumed by the LSU load-queue adaptor. It takes one tag-lookup result per cycle from the L1D load pipeline. For each lookup it either returns a hit response or allocates/merges an MSHR entry and issues a sleep message. It also issues line-refill requests to memory and broadcasts wakeups when refills land or when MSHR capacity returns.

## Interface
Parameters:
- MSHR_D, 4, number of MSHR entries (power of two, ≥2)
- MSHR_ID_W, $clog2(MSHR_D), MSHR index width
- LDQ_ID_W, 5, load id width (same field as lsu_id)
- PADDR_W, 56, physical address width
- LINE_OFF_W, 6, byte-offset bits within a cache line

Ports. Clock is clk; reset is rst_n, asynchronous, active-low.
- clk, in, 1, clock
- rst_n, in, 1, async active-low reset
- lookup_valid_i, in, 1, lookup result valid; always accepted, no ready
- lookup_lsu_id_i, in, LDQ_ID_W, id of the looked-up load
- lookup_paddr_i, in, PADDR_W, load physical address
- lookup_hit_i, in, 1, tag hit
- ld_resp_valid_o, out, 1, hit response
- ld_resp_lsu_id_o, out, LDQ_ID_W, id for the hit response
- l1d_lsu_sleep_valid_o, out, 1, miss notification
- l1d_lsu_sleep_ldq_id_o, out, LDQ_ID_W, sleeping load id
- l1d_lsu_sleep_cache_miss_o, out, 1, always 1 when sleep is valid
- l1d_lsu_sleep_mshr_id_o, out, MSHR_ID_W, entry to wait on; 0 when full
- l1d_lsu_sleep_mshr_full_o, out, 1, no entry available
- l1d_lsu_wakeup_cache_refill_valid_o, out, 1, refill-done broadcast
- l1d_lsu_wakeup_mshr_id_o, out, MSHR_ID_W, refilled entry
- l1d_lsu_wakeup_mshr_avail_o, out, 1, capacity-returned pulse
- mem_req_valid_o, out, 1, refill request
- mem_req_line_o, out, PADDR_W-LINE_OFF_W, line address
- mem_req_mshr_id_o, out, MSHR_ID_W, tag of the request
- mem_req_ready_i, in, 1, memory accepts the request
- mem_refill_valid_i, in, 1, refill complete; no ready
- mem_refill_mshr_id_i, in, MSHR_ID_W, completed entry

## Operation
- Each entry holds state, a line address and a defer bit. Entry states:
  - FREE
  - ALLOC: request not yet sent
  - WAIT: waiting for refill
  - WAKE: wakeup pending
- All lookup decisions use registered state. A lookup in cycle N produces its response or sleep in cycle N+1. There is never more than one response or sleep per cycle.
- Hit: ld_resp_valid_o is asserted with lsu_id. The MSHR is unaffected.
- Miss whose line matches an ALLOC, WAIT or WAKE entry (merge): sleep is issued with that entry's id and mshr_full=0. If the matching entry is in WAKE, its defer bit is set.
- Miss with no match and at least one FREE entry: the lowest FREE index moves to ALLOC with the line stored. Sleep is issued with that id.
- Miss with no match and no FREE entry: sleep is issued with mshr_full=1 and mshr_id=0, and the full_waiter flag is set.
- Memory requests: the lowest-index ALLOC entry drives mem_req. On valid&ready that entry moves ALLOC→WAIT. valid holds until ready.
- Refill: if mem_refill_mshr_id_i names a WAIT entry, that entry moves WAIT→WAKE. A refill for any other state is ignored.
- Wakeup: the lowest-index WAKE entry with defer clear drives the refill wakeup for one cycle, then moves WAKE→FREE.
- Defer: the defer bit clears the cycle the sleep that set it is emitted. This makes the wakeup come at least one cycle after that sleep.
- Capacity wakeup: l1d_lsu_wakeup_mshr_avail_o pulses one cycle when full_waiter_q is set and any entry is FREE in registered state. The flag clears on that pulse. A new full miss in the same cycle re-sets the flag, and set wins.
- Refill and avail wakeups may occur in the same cycle.

## Timing
- Reset: all entries FREE, defer and full_waiter cleared, every output 0.
- Hit-to-response and miss-to-sleep latency: 1 cycle, registered outputs.
- Minimum miss-to-refill-wakeup path:
  - lookup at N
  - ALLOC at N+1, mem_req valid at N+1
  - WAIT at N+2
  - refill at M, WAKE at M+1
  - wakeup at M+1, FREE at M+2
- A freed entry becomes allocatable to the lookup in the cycle after FREE is registered.
- Reset mid-operation drops all entries; no wakeups are issued.

## Configuration
- L1D_MSHR_MERGE_EN defined: secondary-miss merge is enabled as above.
- L1D_MSHR_MERGE_EN undefined: a miss matching an occupied line is treated as a full miss (mshr_full=1, full_waiter set). No duplicate-line entry is ever allocated.

## Structure
- Shared uncore package holds:
  - the entry-state enum (FREE/ALLOC/WAIT/WAKE)
  - the MSHR entry struct
  - the line-address typedef
- One sub-module, l1d_mshr_lowest_sel: a parameterised lowest-set-bit priority select returning valid and index. It is used for the free, alloc and wake selection.

## Test plan
- Hit: lookup hit with lsu_id=7 at N → ld_resp_valid_o=1 with id 7 at N+1; no sleep.
- Miss then refill:
  - stimulus: miss on paddr 0x1040 (lsu_id 3); mem_req_ready_i=1; refill with id 0 three cycles later
  - required: sleep with id 3, mshr 0 at N+1; mem_req line 0x41 at N+1; refill wakeup with mshr 0 the cycle after refill; entry 0 FREE the next cycle
- Merge: two misses to the same line (lsu_id 1 then 2) → both sleeps carry mshr 0 and one mem_req is issued. With L1D_MSHR_MERGE_EN undefined, the second sleep has mshr_full=1.
- Full: four distinct-line misses fill the MSHR; a fifth miss gives mshr_full=1. The first refill wakeup is followed by an avail pulse exactly one cycle after that entry is FREE.
- Defer: a miss matching a WAKE entry at N → sleep at N+1 and the refill wakeup no earlier than N+2.
- Backpressure/reset: hold mem_req_ready_i=0 for 10 cycles → mem_req is stable and the entry stays ALLOC. Assert rst_n=0 mid-WAIT → all outputs 0 and a later refill is ignored.

Source files
------------

// File: rtl/rubytop_l1d_ld_miss_tracker_pkg.sv
// rubytop_l1d_ld_miss_tracker_pkg: shared uncore types for the L1D load-miss tracker.
package rubytop_l1d_ld_miss_tracker_pkg;
  localparam int L1D_PADDR_W    = 56;
  localparam int L1D_LINE_OFF_W = 6;

  typedef logic [L1D_PADDR_W-L1D_LINE_OFF_W-1:0] line_addr_t;

  typedef enum logic [1:0] {
    MSHR_FREE,
    MSHR_ALLOC,
    MSHR_WAIT,
    MSHR_WAKE
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e state;
    logic        defer;
    line_addr_t  line;
  } mshr_entry_t;
endpackage

// File: rtl/rubytop_l1d_ld_miss_tracker_lowest_sel.sv
// l1d_mshr_lowest_sel: lowest-set-bit priority select, index is 0 when nothing is set.
module l1d_mshr_lowest_sel #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = W'(i);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/rubytop_l1d_ld_miss_tracker.sv
// rubytop_l1d_ld_miss_tracker: L1D load-miss MSHR tracker emitting LSU sleep/wakeup messages.
// Define L1D_MSHR_MERGE_EN to merge secondary misses into an existing entry.
module rubytop_l1d_ld_miss_tracker
  import rubytop_l1d_ld_miss_tracker_pkg::*;
#(
  parameter int MSHR_D     = 4,
  parameter int MSHR_ID_W  = $clog2(MSHR_D),
  parameter int LDQ_ID_W   = 5,
  parameter int PADDR_W    = L1D_PADDR_W,
  parameter int LINE_OFF_W = L1D_LINE_OFF_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lookup_valid_i,
  input  logic [LDQ_ID_W-1:0]        lookup_lsu_id_i,
  input  logic [PADDR_W-1:0]         lookup_paddr_i,
  input  logic                       lookup_hit_i,
  output logic                       ld_resp_valid_o,
  output logic [LDQ_ID_W-1:0]        ld_resp_lsu_id_o,
  output logic                       l1d_lsu_sleep_valid_o,
  output logic [LDQ_ID_W-1:0]        l1d_lsu_sleep_ldq_id_o,
  output logic                       l1d_lsu_sleep_cache_miss_o,
  output logic [MSHR_ID_W-1:0]       l1d_lsu_sleep_mshr_id_o,
  output logic                       l1d_lsu_sleep_mshr_full_o,
  output logic                       l1d_lsu_wakeup_cache_refill_valid_o,
  output logic [MSHR_ID_W-1:0]       l1d_lsu_wakeup_mshr_id_o,
  output logic                       l1d_lsu_wakeup_mshr_avail_o,
  output logic                       mem_req_valid_o,
  output logic [PADDR_W-LINE_OFF_W-1:0] mem_req_line_o,
  output logic [MSHR_ID_W-1:0]       mem_req_mshr_id_o,
  input  logic                       mem_req_ready_i,
  input  logic                       mem_refill_valid_i,
  input  logic [MSHR_ID_W-1:0]       mem_refill_mshr_id_i
);
  mshr_entry_t          ent_q [MSHR_D];
  mshr_entry_t          ent_d [MSHR_D];
  logic [MSHR_D-1:0]    free_v, alloc_v, wake_v, match_v, merge_v;
  logic                 free_any, alloc_any, wake_any, match_any;
  logic [MSHR_ID_W-1:0] free_idx, alloc_idx, wake_idx, match_idx;
  line_addr_t           lk_line;
  logic                 miss, merge, alloc_new, full_miss, mem_fire;
  logic                 resp_valid_q, sleep_valid_q, sleep_full_q, full_waiter_q, avail_q;
  logic [LDQ_ID_W-1:0]  resp_id_q, sleep_id_q;
  logic [MSHR_ID_W-1:0] sleep_mshr_q;
  logic                 unused_off;

  assign unused_off = ^lookup_paddr_i[LINE_OFF_W-1:0];
  assign lk_line    = line_addr_t'(lookup_paddr_i[PADDR_W-1:LINE_OFF_W]);
  assign miss       = lookup_valid_i && !lookup_hit_i;

  for (genvar i = 0; i < MSHR_D; i++) begin : g_ent
    assign free_v[i]  = ent_q[i].state == MSHR_FREE;
    assign alloc_v[i] = ent_q[i].state == MSHR_ALLOC;
    assign match_v[i] = !free_v[i] && ent_q[i].line == lk_line;
    assign merge_v[i] = merge && match_v[i];
    // An entry being merged into this cycle must not wake before its new sleeper is told.
    assign wake_v[i]  = ent_q[i].state == MSHR_WAKE && !ent_q[i].defer && !merge_v[i];
  end

  l1d_mshr_lowest_sel #(.N(MSHR_D), .W(MSHR_ID_W)) u_free_sel  (.req_i(free_v),  .valid_o(free_any),  .idx_o(free_idx));
  l1d_mshr_lowest_sel #(.N(MSHR_D), .W(MSHR_ID_W)) u_alloc_sel (.req_i(alloc_v), .valid_o(alloc_any), .idx_o(alloc_idx));
  l1d_mshr_lowest_sel #(.N(MSHR_D), .W(MSHR_ID_W)) u_wake_sel  (.req_i(wake_v),  .valid_o(wake_any),  .idx_o(wake_idx));
  l1d_mshr_lowest_sel #(.N(MSHR_D), .W(MSHR_ID_W)) u_match_sel (.req_i(match_v), .valid_o(match_any), .idx_o(match_idx));

`ifdef L1D_MSHR_MERGE_EN
  assign merge = miss && match_any;
`else
  assign merge = 1'b0;
`endif
  assign alloc_new = miss && !match_any && free_any;
  assign full_miss = miss && !merge && !alloc_new;
  assign mem_fire  = alloc_any && mem_req_ready_i;

  always_comb begin
    for (int i = 0; i < MSHR_D; i++) begin
      ent_d[i] = ent_q[i];
      ent_d[i].defer = merge_v[i] && ent_q[i].state == MSHR_WAKE;
      if (alloc_new && free_idx == MSHR_ID_W'(i)) begin
        ent_d[i].state = MSHR_ALLOC;
        ent_d[i].line  = lk_line;
      end else if (mem_fire && alloc_idx == MSHR_ID_W'(i))
        ent_d[i].state = MSHR_WAIT;
      else if (mem_refill_valid_i && mem_refill_mshr_id_i == MSHR_ID_W'(i) && ent_q[i].state == MSHR_WAIT)
        ent_d[i].state = MSHR_WAKE;
      else if (wake_any && wake_idx == MSHR_ID_W'(i))
        ent_d[i].state = MSHR_FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSHR_D; i++) ent_q[i] <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      sleep_valid_q <= 1'b0;
      sleep_id_q    <= '0;
      sleep_mshr_q  <= '0;
      sleep_full_q  <= 1'b0;
      full_waiter_q <= 1'b0;
      avail_q       <= 1'b0;
    end else begin
      ent_q         <= ent_d;
      resp_valid_q  <= lookup_valid_i && lookup_hit_i;
      resp_id_q     <= lookup_valid_i && lookup_hit_i ? lookup_lsu_id_i : '0;
      sleep_valid_q <= miss;
      sleep_id_q    <= miss ? lookup_lsu_id_i : '0;
      sleep_mshr_q  <= merge ? match_idx : alloc_new ? free_idx : '0;
      sleep_full_q  <= full_miss;
      full_waiter_q <= full_miss || (full_waiter_q && !free_any);
      avail_q       <= full_waiter_q && free_any;
    end
  end

  assign ld_resp_valid_o                     = resp_valid_q;
  assign ld_resp_lsu_id_o                    = resp_id_q;
  assign l1d_lsu_sleep_valid_o               = sleep_valid_q;
  assign l1d_lsu_sleep_ldq_id_o              = sleep_id_q;
  assign l1d_lsu_sleep_cache_miss_o          = sleep_valid_q;
  assign l1d_lsu_sleep_mshr_id_o             = sleep_mshr_q;
  assign l1d_lsu_sleep_mshr_full_o           = sleep_full_q;
  assign l1d_lsu_wakeup_cache_refill_valid_o = wake_any;
  assign l1d_lsu_wakeup_mshr_id_o            = wake_idx;
  assign l1d_lsu_wakeup_mshr_avail_o         = avail_q;
  assign mem_req_valid_o                     = alloc_any;
  assign mem_req_line_o                      = alloc_any ? (PADDR_W-LINE_OFF_W)'(ent_q[alloc_idx].line) : '0;
  assign mem_req_mshr_id_o                   = alloc_idx;
endmodule

// File: tb/tb_rubytop_l1d_ld_miss_tracker.sv
// tb_rubytop_l1d_ld_miss_tracker: directed self-checking bench for the L1D load-miss tracker.
module tb_rubytop_l1d_ld_miss_tracker;
`ifdef L1D_MSHR_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid_i, lookup_hit_i;
  logic [4:0]  lookup_lsu_id_i;
  logic [55:0] lookup_paddr_i;
  logic        ld_resp_valid_o;
  logic [4:0]  ld_resp_lsu_id_o;
  logic        sleep_valid, sleep_cm, sleep_full;
  logic [4:0]  sleep_id;
  logic [1:0]  sleep_mshr;
  logic        wake_valid, avail;
  logic [1:0]  wake_id;
  logic        mem_req_valid_o, mem_req_ready_i, mem_refill_valid_i;
  logic [49:0] mem_req_line_o;
  logic [1:0]  mem_req_mshr_id_o, mem_refill_mshr_id_i;
  logic [72:0] all_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rubytop_l1d_ld_miss_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid_i), .lookup_lsu_id_i(lookup_lsu_id_i),
    .lookup_paddr_i(lookup_paddr_i), .lookup_hit_i(lookup_hit_i),
    .ld_resp_valid_o(ld_resp_valid_o), .ld_resp_lsu_id_o(ld_resp_lsu_id_o),
    .l1d_lsu_sleep_valid_o(sleep_valid), .l1d_lsu_sleep_ldq_id_o(sleep_id),
    .l1d_lsu_sleep_cache_miss_o(sleep_cm), .l1d_lsu_sleep_mshr_id_o(sleep_mshr),
    .l1d_lsu_sleep_mshr_full_o(sleep_full),
    .l1d_lsu_wakeup_cache_refill_valid_o(wake_valid), .l1d_lsu_wakeup_mshr_id_o(wake_id),
    .l1d_lsu_wakeup_mshr_avail_o(avail),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_line_o(mem_req_line_o),
    .mem_req_mshr_id_o(mem_req_mshr_id_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_refill_valid_i(mem_refill_valid_i), .mem_refill_mshr_id_i(mem_refill_mshr_id_i)
  );

  assign all_out = {ld_resp_valid_o, ld_resp_lsu_id_o, sleep_valid, sleep_id, sleep_cm, sleep_mshr,
                    sleep_full, wake_valid, wake_id, avail, mem_req_valid_o, mem_req_line_o, mem_req_mshr_id_o};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic v, input logic h, input logic [4:0] id, input logic [55:0] pa);
    lookup_valid_i  = v;
    lookup_hit_i    = h;
    lookup_lsu_id_i = id;
    lookup_paddr_i  = pa;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    lookup(1'b0, 1'b0, 5'd0, 56'd0);
    mem_req_ready_i = 1'b0;
    mem_refill_valid_i = 1'b0;
    mem_refill_mshr_id_i = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    lookup(1'b1, 1'b1, 5'd9, 56'h40);
    cyc();
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_held outputs got %h want 0", all_out); end
    lookup(1'b0, 1'b0, 5'd0, 56'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_release outputs got %h want 0", all_out); end
  endtask

  task automatic test_hit();
    apply_reset();
    cyc(); lookup(1'b1, 1'b1, 5'd7, 56'h80);
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({ld_resp_valid_o, ld_resp_lsu_id_o, sleep_valid, mem_req_valid_o} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL hit_resp got v=%b id=%0d sleep=%b req=%b want v=1 id=7 sleep=0 req=0",
                         ld_resp_valid_o, ld_resp_lsu_id_o, sleep_valid, mem_req_valid_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ld_resp_valid_o !== 1'b0) begin errors++; $display("FAIL hit_resp_pulse got %b want 0", ld_resp_valid_o); end
  endtask

  task automatic test_miss_refill();
    apply_reset();
    mem_req_ready_i = 1'b1;
    cyc(); lookup(1'b1, 1'b0, 5'd3, 56'h1040);
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_cm, sleep_mshr, sleep_full} !== {1'b1, 5'd3, 1'b1, 2'd0, 1'b0}) begin
      errors++; $display("FAIL miss_sleep got v=%b id=%0d cm=%b mshr=%0d full=%b want 1 3 1 0 0",
                         sleep_valid, sleep_id, sleep_cm, sleep_mshr, sleep_full);
    end
    checks++;
    if ({mem_req_valid_o, mem_req_line_o, mem_req_mshr_id_o} !== {1'b1, 50'h41, 2'd0}) begin
      errors++; $display("FAIL miss_memreq got v=%b line=%h id=%0d want 1 41 0", mem_req_valid_o, mem_req_line_o, mem_req_mshr_id_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({mem_req_valid_o, sleep_valid} !== 2'b00) begin
      errors++; $display("FAIL miss_single_req got req=%b sleep=%b want 0 0", mem_req_valid_o, sleep_valid);
    end
    cyc(); mem_refill_valid_i = 1'b1; mem_refill_mshr_id_i = 2'd0;
    @(negedge clk);
    checks++;
    if (wake_valid !== 1'b0) begin errors++; $display("FAIL refill_early_wake got %b want 0", wake_valid); end
    cyc(); mem_refill_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({wake_valid, wake_id} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL refill_wake got v=%b id=%0d want 1 0", wake_valid, wake_id);
    end
    cyc(); lookup(1'b1, 1'b0, 5'd4, 56'h2000);
    @(negedge clk);
    checks++;
    if (wake_valid !== 1'b0) begin errors++; $display("FAIL refill_wake_pulse got %b want 0", wake_valid); end
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o, mem_req_line_o} !==
        {1'b1, 5'd4, 2'd0, 1'b0, 1'b1, 50'h80}) begin
      errors++; $display("FAIL realloc got v=%b id=%0d mshr=%0d full=%b req=%b line=%h want 1 4 0 0 1 80",
                         sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o, mem_req_line_o);
    end
  endtask

  task automatic test_merge();
    apply_reset();
    mem_req_ready_i = 1'b1;
    cyc(); lookup(1'b1, 1'b0, 5'd1, 56'h3000);
    cyc(); lookup(1'b1, 1'b0, 5'd2, 56'h3008);
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o, mem_req_line_o} !==
        {1'b1, 5'd1, 2'd0, 1'b0, 1'b1, 50'hC0}) begin
      errors++; $display("FAIL merge_first got v=%b id=%0d mshr=%0d full=%b req=%b line=%h want 1 1 0 0 1 c0",
                         sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o, mem_req_line_o);
    end
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o} !== {1'b1, 5'd2, 2'd0, !MERGE, 1'b0}) begin
      errors++; $display("FAIL merge_second got v=%b id=%0d mshr=%0d full=%b req=%b want 1 2 0 %b 0",
                         sleep_valid, sleep_id, sleep_mshr, sleep_full, mem_req_valid_o, !MERGE);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({avail, sleep_valid} !== {!MERGE, 1'b0}) begin
      errors++; $display("FAIL merge_avail got avail=%b sleep=%b want %b 0", avail, sleep_valid, !MERGE);
    end
  endtask

  task automatic test_full();
    apply_reset();
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(); lookup(1'b1, 1'b0, 5'(10 + k), 56'(k + 1) << 14);
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if ({sleep_valid, sleep_id, sleep_mshr, sleep_full} !== {1'b1, 5'(9 + k), 2'(k - 1), 1'b0}) begin
          errors++; $display("FAIL full_fill%0d got v=%b id=%0d mshr=%0d full=%b want 1 %0d %0d 0",
                             k, sleep_valid, sleep_id, sleep_mshr, sleep_full, 9 + k, k - 1);
        end
      end
    end
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_mshr, sleep_full} !== {1'b1, 5'd14, 2'd0, 1'b1}) begin
      errors++; $display("FAIL full_sleep got v=%b id=%0d mshr=%0d full=%b want 1 14 0 1",
                         sleep_valid, sleep_id, sleep_mshr, sleep_full);
    end
    cyc(); mem_refill_valid_i = 1'b1; mem_refill_mshr_id_i = 2'd0;
    @(negedge clk);
    checks++;
    if ({wake_valid, avail} !== 2'b00) begin errors++; $display("FAIL full_pre_refill got wake=%b avail=%b want 0 0", wake_valid, avail); end
    cyc(); mem_refill_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({wake_valid, wake_id, avail} !== {1'b1, 2'd0, 1'b0}) begin
      errors++; $display("FAIL full_wake got v=%b id=%0d avail=%b want 1 0 0", wake_valid, wake_id, avail);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wake_valid, avail} !== 2'b00) begin errors++; $display("FAIL full_free_cycle got wake=%b avail=%b want 0 0", wake_valid, avail); end
    cyc();
    @(negedge clk);
    checks++;
    if (avail !== 1'b1) begin errors++; $display("FAIL full_avail got %b want 1", avail); end
    cyc(); mem_refill_valid_i = 1'b1; mem_refill_mshr_id_i = 2'd0;
    @(negedge clk);
    checks++;
    if (avail !== 1'b0) begin errors++; $display("FAIL full_avail_pulse got %b want 0", avail); end
    cyc(); mem_refill_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wake_valid !== 1'b0) begin errors++; $display("FAIL stale_refill got wake=%b want 0", wake_valid); end
  endtask

  task automatic test_defer();
    apply_reset();
    mem_req_ready_i = 1'b1;
    cyc(); lookup(1'b1, 1'b0, 5'd5, 56'h5000);
    cyc(); lookup_valid_i = 1'b0;
    cyc(); mem_refill_valid_i = 1'b1; mem_refill_mshr_id_i = 2'd0;
    cyc(); mem_refill_valid_i = 1'b0; lookup(1'b1, 1'b0, 5'd6, 56'h5010);
    @(negedge clk);
    checks++;
    if (wake_valid !== !MERGE) begin errors++; $display("FAIL defer_lookup_cycle got wake=%b want %b", wake_valid, !MERGE); end
    cyc(); lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sleep_valid, sleep_id, sleep_mshr, sleep_full, wake_valid} !== {1'b1, 5'd6, 2'd0, !MERGE, 1'b0}) begin
      errors++; $display("FAIL defer_sleep got v=%b id=%0d mshr=%0d full=%b wake=%b want 1 6 0 %b 0",
                         sleep_valid, sleep_id, sleep_mshr, sleep_full, wake_valid, !MERGE);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wake_valid, wake_id, avail} !== {MERGE, 2'd0, !MERGE}) begin
      errors++; $display("FAIL defer_wake got v=%b id=%0d avail=%b want %b 0 %b", wake_valid, wake_id, avail, MERGE, !MERGE);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wake_valid, avail} !== 2'b00) begin errors++; $display("FAIL defer_after got wake=%b avail=%b want 0 0", wake_valid, avail); end
  endtask

  task automatic test_backpressure_reset();
    apply_reset();
    cyc(); lookup(1'b1, 1'b0, 5'd10, 56'h7040);
    cyc(); lookup_valid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid_o, mem_req_line_o, mem_req_mshr_id_o} !== {1'b1, 50'h1C1, 2'd0}) begin
        errors++; $display("FAIL bp_hold%0d got v=%b line=%h id=%0d want 1 1c1 0", k, mem_req_valid_o, mem_req_line_o, mem_req_mshr_id_o);
      end
      cyc();
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", mem_req_valid_o); end
    cyc(); mem_req_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL bp_wait got %b want 0", mem_req_valid_o); end
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midreset_outputs got %h want 0", all_out); end
    cyc(); rst_n = 1'b1;
    cyc(); mem_refill_valid_i = 1'b1; mem_refill_mshr_id_i = 2'd0;
    cyc(); mem_refill_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midreset_refill got %h want 0", all_out); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hit();
    test_miss_refill();
    test_merge();
    test_full();
    test_defer();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
